// File: rtl/batch_scheduler_pkg.sv
// Shared constants and state encoding for the batch scheduler and its benches.
package batch_scheduler_pkg;

   localparam int unsigned ADDR_WIDTH   = 16;
   localparam int unsigned DEFAULT_TILE = 8;

   typedef enum logic [2:0] {
      BS_IDLE,
      BS_FEED,
      BS_DRAIN,
      BS_WRITE,
      BS_DONE
   } bs_state_e;

endpackage

// File: rtl/batch_scheduler_tile_counter.sv
// Up-counter with synchronous clear, enable and a runtime terminal-count limit.
module tile_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] limit_i,
   output logic [W-1:0] value_o,
   output logic         last_o
);

   assign last_o = (value_o == limit_i);

   // Wraps to zero on the terminal count so back-to-back passes need no clear.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         value_o <= '0;
      end else if (en_i) begin
         value_o <= last_o ? '0 : value_o + 1'b1;
      end
   end

endmodule

// File: rtl/batch_scheduler.sv
// Walks every row/column tile pair of an MxKxN product and sequences the
// systolic array feed/drain and the A/B buffer reads and P buffer writes.
module batch_scheduler
   import batch_scheduler_pkg::*;
#(
   parameter int unsigned AW   = ADDR_WIDTH,
   parameter int unsigned TILE = DEFAULT_TILE
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   output logic          busy_o,
   output logic          done_o,
   input  logic [AW-1:0] m_i,
   input  logic [AW-1:0] k_i,
   input  logic [AW-1:0] n_i,
   input  logic [AW-1:0] base_addra_i,
   input  logic [AW-1:0] base_addrb_i,
   input  logic [AW-1:0] base_addrp_i,
   output logic          batch_begin_o,
   output logic          batch_end_o,
   output logic          ensys_o,
   output logic          bubble_o,
   output logic          ena_o,
   output logic [AW-1:0] addra_o,
   output logic          enb_o,
   output logic [AW-1:0] addrb_o,
   output logic          enp_o,
   output logic          wep_o,
   output logic [AW-1:0] addrp_o
);

   localparam int unsigned TS = $clog2(TILE);
   localparam int unsigned JW = $clog2(2 * TILE);
   localparam logic [JW-1:0] DRAIN_LAST = JW'(2 * TILE - 2);
   localparam logic [JW-1:0] WRITE_LAST = JW'(TILE - 1);

   bs_state_e     state;
   logic [AW-1:0] k_q, c_tiles_q, ke_last_q, c_last_q, r_last_q;
   logic [AW-1:0] base_a_q, base_b_q, base_p_q;
   logic [AW-1:0] rk_q, ck_q, rc_q;

   logic [AW:0]   m_sum, n_sum;
   logic [AW-1:0] r_tiles, c_tiles, ke_last;
   logic          zero_dim;

   logic [AW-1:0] t_val, c_val;
   logic [JW-1:0] jd_val, jd_limit;
   logic          t_last, jd_last, c_last, r_last;
   logic          t_clr, t_en, jd_clr, jd_en, cr_clr, c_en, r_en;
   logic          tile_adv, more_tiles;

   // Ceiling divisions use one extra bit so m or n near 2^AW cannot overflow.
   assign m_sum    = {1'b0, m_i} + (AW+1)'(TILE - 1);
   assign n_sum    = {1'b0, n_i} + (AW+1)'(TILE - 1);
   assign r_tiles  = AW'(m_sum >> TS);
   assign c_tiles  = AW'(n_sum >> TS);
   assign ke_last  = (k_i > AW'(TILE)) ? k_i - 1'b1 : AW'(TILE - 1);
   assign zero_dim = (m_i == '0) || (k_i == '0) || (n_i == '0);

   always_comb begin
      t_clr      = (state == BS_IDLE);
      t_en       = (state == BS_FEED);
      jd_clr     = (state != BS_DRAIN) && (state != BS_WRITE);
      jd_en      = !jd_clr;
      jd_limit   = (state == BS_WRITE) ? WRITE_LAST : DRAIN_LAST;
      tile_adv   = (state == BS_WRITE) && jd_last;
      cr_clr     = (state == BS_IDLE);
      c_en       = tile_adv;
      r_en       = tile_adv && c_last;
      more_tiles = !(c_last && r_last);
   end

   tile_counter #(.W(AW)) u_t_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (t_clr),
      .en_i    (t_en),
      .limit_i (ke_last_q),
      .value_o (t_val),
      .last_o  (t_last)
   );

   // One counter times both the drain window and the write rows.
   tile_counter #(.W(JW)) u_jd_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (jd_clr),
      .en_i    (jd_en),
      .limit_i (jd_limit),
      .value_o (jd_val),
      .last_o  (jd_last)
   );

   tile_counter #(.W(AW)) u_c_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (cr_clr),
      .en_i    (c_en),
      .limit_i (c_last_q),
      .value_o (c_val),
      .last_o  (c_last)
   );

   tile_counter #(.W(AW)) u_r_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (cr_clr),
      .en_i    (r_en),
      .limit_i (r_last_q),
      .value_o (),
      .last_o  (r_last)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= BS_IDLE;
         k_q       <= '0;
         c_tiles_q <= '0;
         ke_last_q <= '0;
         c_last_q  <= '0;
         r_last_q  <= '0;
         base_a_q  <= '0;
         base_b_q  <= '0;
         base_p_q  <= '0;
         rk_q      <= '0;
         ck_q      <= '0;
         rc_q      <= '0;
      end else begin
         case (state)
            BS_IDLE: begin
               if (start_i) begin
                  k_q       <= k_i;
                  c_tiles_q <= c_tiles;
                  ke_last_q <= ke_last;
                  c_last_q  <= c_tiles - 1'b1;
                  r_last_q  <= r_tiles - 1'b1;
                  base_a_q  <= base_addra_i;
                  base_b_q  <= base_addrb_i;
                  base_p_q  <= base_addrp_i;
                  rk_q      <= '0;
                  ck_q      <= '0;
                  rc_q      <= '0;
                  state     <= zero_dim ? BS_DONE : BS_FEED;
               end
            end
            BS_FEED: begin
               if (t_last) state <= BS_DRAIN;
            end
            BS_DRAIN: begin
               if (jd_last) state <= BS_WRITE;
            end
            BS_WRITE: begin
               if (jd_last) begin
                  if (more_tiles) begin
                     state <= BS_FEED;
                     // Running products r*k, c*k and r*C track the counters.
                     if (c_last) begin
                        ck_q <= '0;
                        rk_q <= rk_q + k_q;
                        rc_q <= rc_q + c_tiles_q;
                     end else begin
                        ck_q <= ck_q + k_q;
                     end
                  end else begin
                     state <= BS_DONE;
                  end
               end
            end
            BS_DONE: state <= BS_IDLE;
            default: state <= BS_IDLE;
         endcase
      end
   end

   always_comb begin
      busy_o        = (state != BS_IDLE);
      done_o        = 1'b0;
      batch_begin_o = 1'b0;
      batch_end_o   = 1'b0;
      ensys_o       = 1'b0;
      bubble_o      = 1'b0;
      ena_o         = 1'b0;
      addra_o       = '0;
      enb_o         = 1'b0;
      addrb_o       = '0;
      enp_o         = 1'b0;
      wep_o         = 1'b0;
      addrp_o       = '0;
      case (state)
         BS_FEED: begin
            ensys_o       = 1'b1;
            batch_begin_o = (t_val == '0);
            if (t_val < k_q) begin
               ena_o   = 1'b1;
               enb_o   = 1'b1;
               addra_o = base_a_q + rk_q + t_val;
               addrb_o = base_b_q + ck_q + t_val;
            end else begin
               bubble_o = 1'b1;
            end
         end
         BS_DRAIN: begin
            ensys_o  = 1'b1;
            bubble_o = 1'b1;
         end
         BS_WRITE: begin
            enp_o       = 1'b1;
            wep_o       = 1'b1;
            addrp_o     = base_p_q + ((rc_q + c_val) << TS) + AW'(jd_val);
            batch_end_o = jd_last;
         end
         BS_DONE: done_o = 1'b1;
         default: ;
      endcase
   end

endmodule
